// File: rtl/sound_cue_sched_pkg.sv
// Shared constants for the sound cue scheduler: cue indices, per-cue playback
// durations in timebase ticks, and the scheduler state encoding.
package sound_cue_pkg;

  localparam int         NUM_CUES = 9;
  localparam logic [3:0] CUE_IDLE = 4'hF;

  localparam logic [3:0] CUE_DONT_MOVE_05 = 4'd0;
  localparam logic [3:0] CUE_LEVEL_START  = 4'd1;
  localparam logic [3:0] CUE_ALARM        = 4'd2;
  localparam logic [3:0] CUE_CORRECT      = 4'd3;
  localparam logic [3:0] CUE_BEEP         = 4'd4;
  localparam logic [3:0] CUE_RSVD_5       = 4'd5;
  localparam logic [3:0] CUE_RSVD_6       = 4'd6;
  localparam logic [3:0] CUE_GAME_OVER    = 4'd7;
  localparam logic [3:0] CUE_HAPPY_END    = 4'd8;

  localparam logic [15:0] CUE_DUR_TICKS [0:8] = '{
    16'd9400, 16'd11750, 16'd7830, 16'd2400, 16'd420,
    16'd0,    16'd0,     16'd10750, 16'd21500
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Out-of-range indices map to a zero-length cue.
  function automatic logic [15:0] cue_dur(input logic [3:0] idx);
    cue_dur = (idx < 4'd9) ? CUE_DUR_TICKS[idx] : 16'd0;
  endfunction

endpackage

// File: rtl/sound_cue_sched_if.sv
// Request/playback bundle between the game FSM side and the cue scheduler.
interface sound_cue_sched_if;
  logic [8:0] cue_req;
  logic       cue_flush;
  logic [8:0] music;
  logic       busy;
  logic [3:0] cur_cue;
  logic [2:0] queue_count;
  logic [7:0] drop_cnt;

  modport master (
    output cue_req, cue_flush,
    input  music, busy, cur_cue, queue_count, drop_cnt
  );

  modport slave (
    input  cue_req, cue_flush,
    output music, busy, cur_cue, queue_count, drop_cnt
  );
endinterface

// File: rtl/sound_cue_sched_fifo.sv
// Small synchronous FIFO of cue indices with an occupancy count and a
// membership compare so the scheduler can merge duplicate requests.
module cue_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [3:0]    i_push_idx,
  input  logic          i_pop,
  output logic [3:0]    o_head_idx,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full,
  input  logic [3:0]    i_cmp_idx,
  output logic          o_cmp_hit
);

  logic [3:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_hit;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_idx = r_mem[r_rd_ptr];
  assign w_do_push  = i_push & ~o_full;
  assign w_do_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_idx;
  end

  // An entry is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [AW-1:0] w_ofs;
      assign w_ofs     = AW'(gi) - r_rd_ptr;
      assign w_hit[gi] = (r_mem[gi] == i_cmp_idx) && ({1'b0, w_ofs} < r_count);
    end
  endgenerate

  assign o_cmp_hit = |w_hit;

endmodule

// File: rtl/sound_cue_sched.sv
// Serializes game sound requests into one-cycle one-hot start pulses, timing each
// cue from a duration table. Optional re-trigger holdoff: define CUE_HOLDOFF_EN.
module sound_cue_sched #(
  parameter int         TICK_DIV      = 100000,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         MIN_GAP_TICKS = 50,
  parameter logic [8:0] VALID_MASK    = 9'b110011111,
  parameter int         HOLDOFF_TICKS = 1000
) (
  input logic              clk,
  input logic              rst,
  sound_cue_sched_if.slave bus
);
  import sound_cue_pkg::*;

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(MIN_GAP_TICKS + 1);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  logic [8:0]    r_prev;
  logic [8:0]    r_pend;
  logic [3:0]    r_cur_idx;
  logic [15:0]   r_dur;
  logic [GW-1:0] r_gap;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_drop;

  logic          w_tick;
  logic          w_playing;
  logic [8:0]    w_rise;
  logic [8:0]    w_hold;
  logic [8:0]    w_sel_mask;
  logic [3:0]    w_sel_idx;
  logic [3:0]    w_head_idx;
  logic          w_sel_vld;
  logic          w_dup;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_hit;
  logic          w_empty;
  logic          w_full;
  logic [QW-1:0] w_count;

  // Restarting in ISSUE makes PLAY begin on a fresh tick period.
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state == ST_ISSUE) r_presc <= '0;
    else if (w_tick)                r_presc <= '0;
    else                            r_presc <= r_presc + 1'b1;
  end

`ifdef CUE_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_TICKS + 1);
  generate
    for (genvar gi = 0; gi < NUM_CUES; gi++) begin : g_hold
      logic [HW-1:0] r_hold;
      always_ff @(posedge clk) begin
        if (rst)                                                r_hold <= '0;
        else if (r_state == ST_ISSUE && r_cur_idx == 4'(gi))    r_hold <= HW'(HOLDOFF_TICKS);
        else if (w_tick && r_hold != '0)                        r_hold <= r_hold - 1'b1;
      end
      assign w_hold[gi] = (r_hold != '0);
    end
  endgenerate
`else
  assign w_hold = '0;
`endif

  assign w_rise = bus.cue_req & ~r_prev & VALID_MASK & ~w_hold;

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = 4'd0;
    for (int i = NUM_CUES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = 4'(i);
      end
    end
  end

  assign w_sel_mask = w_sel_vld ? (9'd1 << w_sel_idx) : 9'd0;
  assign w_playing  = (r_state == ST_ISSUE) || (r_state == ST_PLAY);
  assign w_dup      = w_hit || (w_playing && r_cur_idx == w_sel_idx);
  assign w_push     = w_sel_vld && !w_dup && !w_full && !bus.cue_flush;
  assign w_drop     = w_sel_vld && !w_dup && w_full && !bus.cue_flush;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty && !bus.cue_flush;

  // Loading the live request level during reset suppresses held-high triggers.
  always_ff @(posedge clk) begin
    r_prev <= bus.cue_req;
    if (rst) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      if (bus.cue_flush) r_pend <= '0;
      else               r_pend <= (r_pend & ~w_sel_mask) | w_rise;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  cue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (bus.cue_flush),
    .i_push     (w_push),
    .i_push_idx (w_sel_idx),
    .i_pop      (w_pop),
    .o_head_idx (w_head_idx),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .i_cmp_idx  (w_sel_idx),
    .o_cmp_hit  (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= CUE_IDLE;
      r_dur     <= '0;
      r_gap     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cur_idx <= w_head_idx;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_dur   <= cue_dur(r_cur_idx);
          r_state <= ST_PLAY;
        end
        ST_PLAY: begin
          // The tick that would bring the count to zero ends playback.
          if (r_dur == 16'd0) begin
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else if (w_tick) begin
            if (r_dur == 16'd1) begin
              r_gap   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_dur <= r_dur - 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            if (r_gap == GW'(MIN_GAP_TICKS - 1)) r_state <= ST_IDLE;
            else                                  r_gap   <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.music       = (r_state == ST_ISSUE) ? (9'd1 << r_cur_idx) : 9'd0;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.cur_cue     = w_playing ? r_cur_idx : CUE_IDLE;
  assign bus.queue_count = 3'(w_count);
  assign bus.drop_cnt    = r_drop;

endmodule
